// File: rtl/alu_ctr_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alu_ctr_pkg
//  Brief    : Shared alu_ctr codes, FSM state encoding and code helpers for
//             the serial execute unit.
//  Revision : 1.0  initial release
// ============================================================================
package alu_ctr_pkg;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_SLT  = 3'b100;
    localparam logic [2:0] ALU_ADD  = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_MOVE = 3'b111;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        SLT_FIX = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Codes 010 and 011 have no operation behind them.
    function automatic logic is_illegal(input logic [2:0] ctr);
        return (ctr == 3'b010) || (ctr == 3'b011);
    endfunction

    // SUB and SLT both run the adder with B inverted and a carry-in of one.
    function automatic logic is_subtract(input logic [2:0] ctr);
        return (ctr == ALU_SUB) || (ctr == ALU_SLT);
    endfunction

endpackage : alu_ctr_pkg
`default_nettype wire

// File: rtl/alu_digit_slice.sv
`default_nettype none
// ============================================================================
//  Module   : alu_digit_slice
//  Brief    : Combinational DIGIT-wide slice of the serial ALU. Produces the
//             slice result, the carry out and the carry into the slice MSB
//             (the latter two give signed overflow on the final slice).
//  Revision : 1.0  initial release
// ============================================================================
module alu_digit_slice
    import alu_ctr_pkg::*;
#(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] i_a,
    input  logic [DIGIT-1:0] i_b,
    input  logic [2:0]       i_ctr,
    input  logic             i_cin,
    output logic [DIGIT-1:0] o_sum,
    output logic             o_cout,
    output logic             o_cmsb
);

    logic [DIGIT-1:0] w_bx;
    logic [DIGIT:0]   w_add;

    assign w_bx   = is_subtract(i_ctr) ? ~i_b : i_b;
    assign w_add  = {1'b0, i_a} + {1'b0, w_bx} + {{DIGIT{1'b0}}, i_cin};
    assign o_cout = w_add[DIGIT];
    // The MSB sum bit is a ^ b ^ carry-in, so the carry into the MSB falls out
    // of the same adder without a second, narrower add.
    assign o_cmsb = i_a[DIGIT-1] ^ w_bx[DIGIT-1] ^ w_add[DIGIT-1];

    // Select the slice result for the operation in flight.
    always_comb begin
        o_sum = w_add[DIGIT-1:0];
        case (i_ctr)
            ALU_AND:  o_sum = i_a & i_b;
            ALU_OR:   o_sum = i_a | i_b;
            ALU_MOVE: o_sum = i_a;
            default:  o_sum = w_add[DIGIT-1:0];
        endcase
    end

endmodule : alu_digit_slice
`default_nettype wire

// File: rtl/alu_ctr_serial_exec.sv
`default_nettype none
// ============================================================================
//  Module   : alu_ctr_serial_exec
//  Brief    : Multi-cycle EX-stage execute unit. Accepts alu_ctr and operands
//             on a start handshake, evaluates DIGIT bits per cycle LSB first,
//             and returns result/zero/illegal on a result handshake.
//  Revision : 1.0  initial release
// ============================================================================
module alu_ctr_serial_exec
    import alu_ctr_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start_valid,
    output logic             o_start_ready,
    input  logic [2:0]       i_alu_ctr,
    input  logic [WIDTH-1:0] i_op_a,
    input  logic [WIDTH-1:0] i_op_b,
    output logic             o_res_valid,
    input  logic             i_res_ready,
    output logic [WIDTH-1:0] o_result,
    output logic             o_zero,
    output logic             o_illegal
);

    localparam int NSLICE = WIDTH / DIGIT;
    localparam int CW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NSLICE - 1);

    if ((WIDTH % DIGIT) != 0) begin : g_bad_digit
        $error("alu_ctr_serial_exec: DIGIT must divide WIDTH");
    end

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [2:0]        r_ctr;
    logic              r_carry;
    logic [CW-1:0]     r_cnt;
    logic [WIDTH-1:0]  r_acc;
    logic [WIDTH-1:0]  r_result;
    logic              r_zero;
    logic              r_illegal;
    logic              r_slt_bit;

    logic [DIGIT-1:0]  w_sum;
    logic              w_cout;
    logic              w_cmsb;
    logic              w_last;
    logic [WIDTH-1:0]  w_acc_nxt;

    alu_digit_slice #(
        .DIGIT (DIGIT)
    ) u_slice (
        .i_a    (r_a[DIGIT-1:0]),
        .i_b    (r_b[DIGIT-1:0]),
        .i_ctr  (r_ctr),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout),
        .o_cmsb (w_cmsb)
    );

    assign w_last = (r_cnt == LAST_CNT);

    // New slices enter at the top of the accumulator so that after the last
    // slice the first one has reached bit 0.
    if (NSLICE == 1) begin : g_acc_single
        assign w_acc_nxt = w_sum;
    end else begin : g_acc_shift
        assign w_acc_nxt = {w_sum, r_acc[WIDTH-1:DIGIT]};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (i_start_valid) begin
                    w_state_nxt = is_illegal(i_alu_ctr) ? DONE : RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_nxt = (r_ctr == ALU_SLT) ? SLT_FIX : DONE;
                end
            end
            SLT_FIX: w_state_nxt = DONE;
            DONE: begin
                if (i_res_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operand shifters, carry chain, accumulator and presented result. The
    // visible result only changes when a complete answer is ready.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a       <= '0;
            r_b       <= '0;
            r_ctr     <= ALU_AND;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_acc     <= '0;
            r_result  <= '0;
            r_zero    <= 1'b0;
            r_illegal <= 1'b0;
            r_slt_bit <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_start_valid) begin
                        r_a       <= i_op_a;
                        r_b       <= i_op_b;
                        r_ctr     <= i_alu_ctr;
                        r_carry   <= is_subtract(i_alu_ctr);
                        r_cnt     <= '0;
                        r_acc     <= '0;
                        r_illegal <= is_illegal(i_alu_ctr);
                        if (is_illegal(i_alu_ctr)) begin
                            r_result <= '0;
                            r_zero   <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r_a       <= r_a >> DIGIT;
                    r_b       <= r_b >> DIGIT;
                    r_carry   <= w_cout;
                    r_cnt     <= r_cnt + 1'b1;
                    r_acc     <= w_acc_nxt;
                    // Signed less-than: sign of the difference corrected by overflow.
                    r_slt_bit <= w_sum[DIGIT-1] ^ w_cmsb ^ w_cout;
                    if (w_last && (r_ctr != ALU_SLT)) begin
                        r_result <= w_acc_nxt;
                        r_zero   <= (w_acc_nxt == '0);
                    end
                end
                SLT_FIX: begin
                    r_result <= {{(WIDTH-1){1'b0}}, r_slt_bit};
                    r_zero   <= ~r_slt_bit;
                end
                default: begin
                end
            endcase
        end
    end

    assign o_start_ready = (r_state == IDLE);
    assign o_res_valid   = (r_state == DONE);
    assign o_result      = r_result;
    assign o_zero        = r_zero;
    assign o_illegal     = r_illegal;

endmodule : alu_ctr_serial_exec
`default_nettype wire

// File: tb/tb_alu_ctr_serial_exec.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_ctr_serial_exec
//  Brief    : Self-checking bench for alu_ctr_serial_exec with an arithmetic
//             reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_ctr_serial_exec;

    logic        clk;
    logic        rst_n;
    logic        start_valid;
    logic        start_ready;
    logic [2:0]  alu_ctr;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    int total;
    int bad;

    alu_ctr_serial_exec #(
        .WIDTH (32),
        .DIGIT (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start_valid (start_valid),
        .o_start_ready (start_ready),
        .i_alu_ctr     (alu_ctr),
        .i_op_a        (op_a),
        .i_op_b        (op_b),
        .o_res_valid   (res_valid),
        .i_res_ready   (res_ready),
        .o_result      (result),
        .o_zero        (zero),
        .o_illegal     (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {illegal, zero, result} straight from the operation table.
    function automatic logic [33:0] ref_op(input logic [2:0] c, input logic [31:0] a,
                                           input logic [31:0] b);
        logic [31:0] r;
        logic        il;
        r  = 32'd0;
        il = 1'b0;
        case (c)
            3'b000:  r = a & b;
            3'b001:  r = a | b;
            3'b101:  r = a + b;
            3'b110:  r = a - b;
            3'b100:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'b111:  r = a;
            default: il = 1'b1;
        endcase
        return {il, (r == 32'd0), r};
    endfunction

    // Edges after the accept edge until res_valid is seen (0 = right after accept).
    function automatic int ref_lat(input logic [2:0] c);
        if (c == 3'b010 || c == 3'b011) return 0;
        if (c == 3'b100) return 9;
        return 8;
    endfunction

    // Issue one request, wait for the result, sample it, then complete the handshake.
    task automatic do_op(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b,
                         output logic [31:0] r, output logic z, output logic il,
                         output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!start_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        start_valid = 1'b1;
        alu_ctr     = c;
        op_a        = a;
        op_b        = b;
        res_ready   = 1'b0;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        alu_ctr     = 3'($urandom);
        op_a        = $urandom;
        op_b        = $urandom;
        lat = 0;
        while (!res_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        r  = result;
        z  = zero;
        il = illegal;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n       = 1'b0;
        start_valid = 1'b0;
        res_ready   = 1'b0;
        alu_ctr     = 3'b000;
        op_a        = 32'd0;
        op_b        = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        total++; if (start_ready !== 1'b1) begin bad++; $display("FAIL reset_start_ready got=%b want=1", start_ready); end
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL reset_res_valid got=%b want=0", res_valid); end
        total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h want=0", result); end
        total++; if (zero !== 1'b0) begin bad++; $display("FAIL reset_zero got=%b want=0", zero); end
        total++; if (illegal !== 1'b0) begin bad++; $display("FAIL reset_illegal got=%b want=0", illegal); end
    endtask

    task automatic test_directed();
        logic [2:0]  vc [10];
        logic [31:0] va [10];
        logic [31:0] vb [10];
        logic [31:0] vr [10];
        logic [33:0] m;
        logic [31:0] r;
        logic        z, il;
        int          lat;
        vc = '{3'b101, 3'b110, 3'b110, 3'b100, 3'b100, 3'b000, 3'b001, 3'b111, 3'b010, 3'b011};
        va = '{32'h7FFFFFFF, 32'h5, 32'h0, 32'hFFFFFFFF, 32'h7FFFFFFF,
               32'hF0F0F0F0, 32'hF0F0F0F0, 32'hF0F0F0F0, 32'h1234, 32'h5678};
        vb = '{32'h1, 32'h5, 32'h1, 32'h1, 32'h80000000,
               32'h0FF00FF0, 32'h0FF00FF0, 32'h0FF00FF0, 32'h1, 32'h2};
        vr = '{32'h80000000, 32'h0, 32'hFFFFFFFF, 32'h1, 32'h0,
               32'h00F000F0, 32'hFFF0FFF0, 32'hF0F0F0F0, 32'h0, 32'h0};
        for (int i = 0; i < 10; i++) begin
            m = ref_op(vc[i], va[i], vb[i]);
            do_op(vc[i], va[i], vb[i], r, z, il, lat);
            total++; if (r !== vr[i]) begin bad++; $display("FAIL directed%0d_result got=%h want=%h", i, r, vr[i]); end
            total++; if (z !== m[32]) begin bad++; $display("FAIL directed%0d_zero got=%b want=%b", i, z, m[32]); end
            total++; if (il !== m[33]) begin bad++; $display("FAIL directed%0d_illegal got=%b want=%b", i, il, m[33]); end
            total++; if (lat != ref_lat(vc[i])) begin bad++; $display("FAIL directed%0d_latency got=%0d want=%0d", i, lat, ref_lat(vc[i])); end
        end
    endtask

    task automatic test_random();
        logic [2:0]  c;
        logic [31:0] a, b, r;
        logic [33:0] m;
        logic        z, il;
        int          lat;
        for (int i = 0; i < 60; i++) begin
            c = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            if (i % 5 == 0) b = a;
            if (i % 7 == 0) a = 32'($urandom_range(0, 3)) << 30;
            m = ref_op(c, a, b);
            do_op(c, a, b, r, z, il, lat);
            total++; if (r !== m[31:0]) begin bad++; $display("FAIL rand%0d_result ctr=%b a=%h b=%h got=%h want=%h", i, c, a, b, r, m[31:0]); end
            total++; if (z !== m[32]) begin bad++; $display("FAIL rand%0d_zero got=%b want=%b", i, z, m[32]); end
            total++; if (il !== m[33]) begin bad++; $display("FAIL rand%0d_illegal got=%b want=%b", i, il, m[33]); end
            total++; if (lat != ref_lat(c)) begin bad++; $display("FAIL rand%0d_latency got=%0d want=%0d", i, lat, ref_lat(c)); end
            total++; if (start_ready !== 1'b1 || res_valid !== 1'b0) begin bad++; $display("FAIL rand%0d_after_handshake got ready=%b valid=%b want ready=1 valid=0", i, start_ready, res_valid); end
        end
    endtask

    task automatic test_backpressure();
        logic [33:0] m;
        int          lat;
        m = ref_op(3'b101, 32'h12345678, 32'h11111111);
        @(negedge clk);
        start_valid = 1'b1;
        alu_ctr     = 3'b101;
        op_a        = 32'h12345678;
        op_b        = 32'h11111111;
        res_ready   = 1'b0;
        @(posedge clk);
        #1;
        // start_valid stays high with different operands; it must be ignored.
        op_a = 32'hDEADBEEF;
        op_b = 32'h0;
        lat  = 0;
        while (!res_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        total++; if (lat != 8) begin bad++; $display("FAIL bp_latency got=%0d want=8", lat); end
        for (int i = 0; i < 5; i++) begin
            total++; if (result !== m[31:0] || res_valid !== 1'b1 || start_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d got result=%h valid=%b ready=%b want result=%h valid=1 ready=0", i, result, res_valid, start_ready, m[31:0]);
            end
            @(posedge clk);
            #1;
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        total++; if (res_valid !== 1'b0 || start_ready !== 1'b1) begin bad++; $display("FAIL bp_release got valid=%b ready=%b want valid=0 ready=1", res_valid, start_ready); end
        start_valid = 1'b0;
        res_ready   = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [31:0] a, b, want;
        int          lat;
        res_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            a    = $urandom;
            b    = $urandom;
            want = a - b;
            @(negedge clk);
            total++; if (start_ready !== 1'b1) begin bad++; $display("FAIL b2b%0d_ready got=%b want=1", k, start_ready); end
            start_valid = 1'b1;
            alu_ctr     = 3'b110;
            op_a        = a;
            op_b        = b;
            @(posedge clk);
            #1;
            alu_ctr = 3'b000;
            op_a    = $urandom;
            lat     = 0;
            while (!res_valid && lat < 40) begin
                @(posedge clk);
                #1;
                lat++;
            end
            total++; if (result !== want || lat != 8) begin bad++; $display("FAIL b2b%0d got result=%h lat=%0d want result=%h lat=8", k, result, lat, want); end
            start_valid = 1'b0;
            @(posedge clk);
            #1;
        end
        res_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        logic [31:0] r;
        logic        z, il;
        int          lat;
        do_op(3'b111, 32'hA5A5A5A5, 32'h0, r, z, il, lat);
        total++; if (r !== 32'hA5A5A5A5) begin bad++; $display("FAIL ar_pre got=%h want=a5a5a5a5", r); end
        @(negedge clk);
        start_valid = 1'b1;
        alu_ctr     = 3'b101;
        op_a        = 32'h1;
        op_b        = 32'h2;
        @(posedge clk);
        #1;
        start_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        total++; if (res_valid !== 1'b0) begin bad++; $display("FAIL ar_valid got=%b want=0", res_valid); end
        total++; if (result !== 32'd0) begin bad++; $display("FAIL ar_result got=%h want=0", result); end
        total++; if (illegal !== 1'b0 || zero !== 1'b0) begin bad++; $display("FAIL ar_flags got zero=%b illegal=%b want 0 0", zero, illegal); end
        @(negedge clk);
        rst_n = 1'b1;
        do_op(3'b110, 32'd10, 32'd3, r, z, il, lat);
        total++; if (r !== 32'd7 || z !== 1'b0 || lat != 8) begin bad++; $display("FAIL ar_after got result=%h zero=%b lat=%0d want 7 0 8", r, z, lat); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_back_to_back();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_alu_ctr_serial_exec
`default_nettype wire
